mem_agu_pipeline: RTL and testbench

//  Parametrised address-generation / memory-issue stage between the LSU reservation station and the

---
 rtl/mem_agu_pipeline_pkg.sv | 7 +
 rtl/mem_agu_addr_gen.sv | 40 ++++
 rtl/mem_agu_pipeline.sv | 120 ++++++++++++
 tb/tb_mem_agu_pipeline.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_agu_pipeline_pkg.sv
// Shared field positions and page geometry for the memory AGU pipeline.
package mem_agu_pipeline_pkg;
  localparam int IMM_PAGEWRAP_BIT = 3;
  localparam int IMM_SIGNED_BIT   = 2;
  localparam int OPC_STORE_BIT    = 0;
  localparam int PAGE_BITS        = 8;
endpackage

// File: rtl/mem_agu_addr_gen.sv
// Combinational effective-address generator: extends the offset, adds it to the base
// with either full carry or wrap inside the 256-byte page, and flags page crossings.
module mem_agu_addr_gen
  import mem_agu_pipeline_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int OFF_W  = 8,
  parameter int IMM_W  = 4
) (
  input  logic [ADDR_W-1:0] base_val,
  input  logic [OFF_W-1:0]  offset,
  input  logic [IMM_W-1:0]  imm,
  output logic [ADDR_W-1:0] addr,
  output logic              page_cross
);
  logic signed [ADDR_W-1:0] w_ext;
  logic        [ADDR_W-1:0] w_sum;
  logic [PAGE_BITS-1:0]     w_low;
  logic [IMM_W-1:0]         w_unused_imm;

  assign w_unused_imm = imm;

  always_comb begin
    w_ext = '0;
    if (imm[IMM_SIGNED_BIT])
      w_ext = ADDR_W'($signed(offset));
    else
      w_ext = ADDR_W'(offset);
    w_sum = base_val + w_ext;
    // Page-wrap mode keeps only the low-byte sum; the carry out is deliberately lost.
    w_low = base_val[PAGE_BITS-1:0] + w_ext[PAGE_BITS-1:0];
    if (imm[IMM_PAGEWRAP_BIT]) begin
      addr       = {base_val[ADDR_W-1:PAGE_BITS], w_low};
      page_cross = 1'b0;
    end else begin
      addr       = w_sum;
      page_cross = (w_sum[ADDR_W-1:PAGE_BITS] != base_val[ADDR_W-1:PAGE_BITS]);
    end
  end
endmodule

// File: rtl/mem_agu_pipeline.sv
// AGU issue stage: computes the effective address and queues results in a DEPTH-entry
// FIFO so downstream backpressure never reaches input_ready combinationally.
module mem_agu_pipeline
  import mem_agu_pipeline_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int OFF_W  = 8,
  parameter int PREG_W = 5,
  parameter int AREG_W = 8,
  parameter int OPC_W  = 4,
  parameter int IMM_W  = 4,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [OPC_W-1:0]           opcode,
  input  logic [ADDR_W-1:0]          base_val,
  input  logic [OFF_W-1:0]           offset,
  input  logic [PREG_W-1:0]          dest_reg,
  input  logic [DATA_W-1:0]          data,
  input  logic [IMM_W-1:0]           imm,
  input  logic [AREG_W-1:0]          dest_arch_regs,
  input  logic                       input_valid,
  output logic                       input_ready,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [PREG_W-1:0]          dest_reg_out,
  output logic [DATA_W-1:0]          data_out,
  output logic [AREG_W-1:0]          dest_arch_regs_out,
  output logic                       store_out,
  output logic                       page_cross,
  output logic                       output_valid,
  input  logic                       output_ready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              pcross;
    logic              store;
    logic [PREG_W-1:0] dreg;
    logic [DATA_W-1:0] sdata;
    logic [AREG_W-1:0] amask;
  } entry_t;

  entry_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_cnt;

  logic [ADDR_W-1:0]  w_addr;
  logic               w_pcross;
  logic               w_push;
  logic               w_pop;
  entry_t             w_entry;
  entry_t             w_head;
  logic [OPC_W-1:0]   w_unused_opc;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  mem_agu_addr_gen #(
    .ADDR_W (ADDR_W),
    .OFF_W  (OFF_W),
    .IMM_W  (IMM_W)
  ) u_addr_gen (
    .base_val   (base_val),
    .offset     (offset),
    .imm        (imm),
    .addr       (w_addr),
    .page_cross (w_pcross)
  );

  assign w_unused_opc = opcode;
  assign w_entry      = '{addr: w_addr, pcross: w_pcross, store: opcode[OPC_STORE_BIT],
                          dreg: dest_reg, sdata: data, amask: dest_arch_regs};

  assign input_ready  = (r_cnt < CNT_W'(DEPTH));
  assign output_valid = (r_cnt != '0);
  assign occupancy    = r_cnt;
  assign w_push       = input_valid & input_ready & ~flush;
  assign w_pop        = output_valid & output_ready & ~flush;

  assign w_head             = r_mem[r_rd_ptr];
  assign mem_addr           = w_head.addr;
  assign page_cross         = w_head.pcross;
  assign store_out          = w_head.store;
  assign dest_reg_out       = w_head.dreg;
  assign data_out           = w_head.sdata;
  assign dest_arch_regs_out = w_head.amask;

  // Storage is cleared on reset so the head outputs read as zero; flush only resets control.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_entry;
        r_wr_ptr        <= next_ptr(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_agu_pipeline.sv
// Bench for mem_agu_pipeline: DEPTH=2 and DEPTH=3 instances share one stimulus stream and
// are compared every cycle against a queue-based model, plus literal address/flow checks.
module tb_mem_agu_pipeline;
  logic        clk = 1'b0;
  logic        rst_n, flush, input_valid, output_ready;
  logic [3:0]  opcode, imm;
  logic [15:0] base_val;
  logic [7:0]  offset, data, dest_arch_regs;
  logic [4:0]  dest_reg;

  logic        a_input_ready, a_store_out, a_page_cross, a_output_valid;
  logic [15:0] a_mem_addr;
  logic [4:0]  a_dest_reg_out;
  logic [7:0]  a_data_out, a_dest_arch_regs_out;
  logic [1:0]  a_occupancy;
  logic        b_input_ready, b_store_out, b_page_cross, b_output_valid;
  logic [15:0] b_mem_addr;
  logic [4:0]  b_dest_reg_out;
  logic [7:0]  b_data_out, b_dest_arch_regs_out;
  logic [1:0]  b_occupancy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_agu_pipeline #(.DEPTH(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .opcode(opcode), .base_val(base_val),
    .offset(offset), .dest_reg(dest_reg), .data(data), .imm(imm),
    .dest_arch_regs(dest_arch_regs), .input_valid(input_valid), .input_ready(a_input_ready),
    .mem_addr(a_mem_addr), .dest_reg_out(a_dest_reg_out), .data_out(a_data_out),
    .dest_arch_regs_out(a_dest_arch_regs_out), .store_out(a_store_out),
    .page_cross(a_page_cross), .output_valid(a_output_valid), .output_ready(output_ready),
    .occupancy(a_occupancy));

  mem_agu_pipeline #(.DEPTH(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .opcode(opcode), .base_val(base_val),
    .offset(offset), .dest_reg(dest_reg), .data(data), .imm(imm),
    .dest_arch_regs(dest_arch_regs), .input_valid(input_valid), .input_ready(b_input_ready),
    .mem_addr(b_mem_addr), .dest_reg_out(b_dest_reg_out), .data_out(b_data_out),
    .dest_arch_regs_out(b_dest_arch_regs_out), .store_out(b_store_out),
    .page_cross(b_page_cross), .output_valid(b_output_valid), .output_ready(output_ready),
    .occupancy(b_occupancy));

  typedef struct {
    logic [15:0] addr;
    logic        pc;
    logic        st;
    logic [4:0]  dr;
    logic [7:0]  dt;
    logic [7:0]  am;
  } ent_t;

  ent_t qa[$];
  ent_t qb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic ent_t model_entry();
    ent_t e;
    int b, x, s;
    b = int'(base_val);
    x = imm[2] ? int'($signed(offset)) : int'(offset);
    s = b + x;
    if (imm[3]) begin
      e.addr = 16'((b & 'hFF00) | (s & 'hFF));
      e.pc   = 1'b0;
    end else begin
      e.addr = 16'(s & 'hFFFF);
      e.pc   = ((int'(e.addr) >> 8) != (b >> 8));
    end
    e.st = opcode[0];
    e.dr = dest_reg;
    e.dt = data;
    e.am = dest_arch_regs;
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qa.delete();
      qb.delete();
    end else if (flush) begin
      qa.delete();
      qb.delete();
    end else begin
      ent_t e;
      bit pa, ua, pb, ub;
      e  = model_entry();
      pa = (qa.size() != 0) && output_ready;
      ua = input_valid && (qa.size() < 2);
      pb = (qb.size() != 0) && output_ready;
      ub = input_valid && (qb.size() < 3);
      if (pa) qa.delete(0);
      if (ua) qa.push_back(e);
      if (pb) qb.delete(0);
      if (ub) qb.push_back(e);
    end
  end

  task automatic cmp(input string p, input int n, input int d, input ent_t h,
                     input logic v, input logic [1:0] occ, input logic rdy,
                     input logic [15:0] ad, input logic pcx, input logic st,
                     input logic [4:0] dr, input logic [7:0] dt, input logic [7:0] am);
    chk({p, "_output_valid"}, v, n != 0);
    chk({p, "_occupancy"}, occ, n);
    chk({p, "_input_ready"}, rdy, n < d);
    if (n != 0) begin
      chk({p, "_mem_addr"}, ad, h.addr);
      chk({p, "_page_cross"}, pcx, h.pc);
      chk({p, "_store_out"}, st, h.st);
      chk({p, "_dest_reg_out"}, dr, h.dr);
      chk({p, "_data_out"}, dt, h.dt);
      chk({p, "_arch_out"}, am, h.am);
    end
  endtask

  always @(negedge clk) begin
    ent_t ha, hb;
    ha = '{default: '0};
    hb = '{default: '0};
    if (qa.size() != 0) ha = qa[0];
    if (qb.size() != 0) hb = qb[0];
    cmp("a", qa.size(), 2, ha, a_output_valid, a_occupancy, a_input_ready, a_mem_addr,
        a_page_cross, a_store_out, a_dest_reg_out, a_data_out, a_dest_arch_regs_out);
    cmp("b", qb.size(), 3, hb, b_output_valid, b_occupancy, b_input_ready, b_mem_addr,
        b_page_cross, b_store_out, b_dest_reg_out, b_data_out, b_dest_arch_regs_out);
  end

  task automatic set_beat(input logic v, input logic [15:0] b, input logic [7:0] o,
                          input logic [3:0] m, input logic [3:0] op, input logic [7:0] k);
    input_valid    = v;
    base_val       = b;
    offset         = o;
    imm            = m;
    opcode         = op;
    dest_reg       = k[4:0];
    data           = k ^ 8'h5A;
    dest_arch_regs = ~k;
  endtask

  task automatic step(input logic ordy, input logic fl);
    output_ready = ordy;
    flush        = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    input_valid = 1'b0;
    for (int i = 0; i < n; i++) step(1'b1, 1'b0);
  endtask

  initial begin
    int pops;
    rst_n = 1'b0;
    flush = 1'b0;
    output_ready = 1'b0;
    set_beat(1'b0, 16'h0, 8'h0, 4'h0, 4'h0, 8'h0);
    #2;
    chk("rst_valid", a_output_valid, 1'b0);
    chk("rst_occ", a_occupancy, 2'd0);
    chk("rst_ready", a_input_ready, 1'b1);
    chk("rst_addr", a_mem_addr, 16'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Addressing modes, each beat checked at the head and then popped.
    set_beat(1'b1, 16'h12F0, 8'h20, 4'h0, 4'h1, 8'h01);
    step(1'b0, 1'b0);
    chk("mode0_addr", a_mem_addr, 16'h1310);
    chk("mode0_pc", a_page_cross, 1'b1);
    chk("mode0_store", a_store_out, 1'b1);
    drain(1);
    set_beat(1'b1, 16'h12F0, 8'h20, 4'h8, 4'h0, 8'h02);
    step(1'b0, 1'b0);
    chk("wrap_addr", a_mem_addr, 16'h1210);
    chk("wrap_pc", a_page_cross, 1'b0);
    drain(1);
    set_beat(1'b1, 16'h12F0, 8'hF0, 4'h4, 4'h0, 8'h03);
    step(1'b0, 1'b0);
    chk("signed_addr", a_mem_addr, 16'h12E0);
    chk("signed_pc", a_page_cross, 1'b0);
    drain(1);
    set_beat(1'b1, 16'hFFFF, 8'h01, 4'h0, 4'h0, 8'h04);
    step(1'b0, 1'b0);
    chk("top_addr", a_mem_addr, 16'h0000);
    chk("top_pc", a_page_cross, 1'b1);
    drain(2);

    // Streaming: 20 beats with output_ready held high.
    pops = 0;
    for (int i = 0; i < 20; i++) begin
      if (a_output_valid) pops++;
      set_beat(1'b1, 16'(i * 16'h0123), 8'(i * 7), 4'(i % 16), 4'(i), 8'(i + 16));
      step(1'b1, 1'b0);
    end
    chk("stream_pops", pops, 19);
    drain(4);

    // Backpressure on the DEPTH=2 instance.
    set_beat(1'b1, 16'h0400, 8'h10, 4'h0, 4'h1, 8'h21);
    step(1'b0, 1'b0);
    set_beat(1'b1, 16'h0500, 8'h11, 4'h0, 4'h0, 8'h22);
    step(1'b0, 1'b0);
    set_beat(1'b1, 16'h0600, 8'h12, 4'h0, 4'h1, 8'h23);
    step(1'b0, 1'b0);
    chk("bp_occ", a_occupancy, 2'd2);
    chk("bp_ready", a_input_ready, 1'b0);
    chk("bp_head", a_mem_addr, 16'h0410);
    step(1'b1, 1'b0);
    chk("bp_head2", a_mem_addr, 16'h0511);
    step(1'b1, 1'b0);
    chk("bp_head3", a_mem_addr, 16'h0612);
    drain(5);

    // Flush with push and pop requested in the same cycle.
    set_beat(1'b1, 16'h0700, 8'h01, 4'h0, 4'h0, 8'h31);
    step(1'b0, 1'b0);
    set_beat(1'b1, 16'h0800, 8'h02, 4'h0, 4'h0, 8'h32);
    step(1'b0, 1'b0);
    chk("fl_pre_occ", a_occupancy, 2'd2);
    set_beat(1'b1, 16'h0900, 8'h03, 4'h0, 4'h0, 8'h33);
    step(1'b1, 1'b1);
    chk("fl_occ", a_occupancy, 2'd0);
    chk("fl_valid", a_output_valid, 1'b0);
    chk("fl_occ_b", b_occupancy, 2'd0);
    input_valid = 1'b0;
    step(1'b1, 1'b0);
    chk("fl_after", a_output_valid, 1'b0);

    // Random stalls, exercising pointer wrap at DEPTH=3.
    for (int i = 0; i < 40; i++) begin
      set_beat(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom), 4'($urandom),
               4'($urandom), 8'($urandom));
      step(1'($urandom_range(0, 1)), 1'b0);
    end
    drain(4);

    // Asynchronous reset while entries are held.
    set_beat(1'b1, 16'h0A00, 8'h05, 4'h0, 4'h0, 8'h41);
    step(1'b0, 1'b0);
    set_beat(1'b1, 16'h0B00, 8'h06, 4'h0, 4'h0, 8'h42);
    step(1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", a_output_valid, 1'b0);
    chk("mrst_occ", a_occupancy, 2'd0);
    chk("mrst_ready", a_input_ready, 1'b1);
    chk("mrst_addr", a_mem_addr, 16'h0);
    chk("mrst_b_valid", b_output_valid, 1'b0);
    input_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 1'b0);
    chk("mrst_after", a_occupancy, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
